// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer/counter on the ARMSC data bus.
// The block provides a compare match with optional auto-reload, an overflow flag
// and a registered level interrupt.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   MemWrite   processor write strobe; the write commits at the clk edge
//   DataAdr    byte address; the window is BASE..BASE+0x1F
//   WriteData  write data
//   ReadData   combinational read data; 0 when hit is low
//   hit        combinational window decode, for the top-level read mux
//   irq        registered interrupt = STATUS.MATCH & CTRL.IRQEN
//
// Register map (word offsets):
//   0 CTRL      bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
//   1 COUNT     32-bit counter
//   2 COMPARE   32-bit compare value
//   3 STATUS    bit0 MATCH, bit1 OVF (write 1 to clear)
//   4 PRESCALE  low PRESCALE_W bits
//   5-7         read 0, writes ignored
module mmio_timer #(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 3;

  localparam logic [OFF_W-1:0] OFF_CTRL     = 3'd0;
  localparam logic [OFF_W-1:0] OFF_COUNT    = 3'd1;
  localparam logic [OFF_W-1:0] OFF_COMPARE  = 3'd2;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 3'd3;
  localparam logic [OFF_W-1:0] OFF_PRESCALE = 3'd4;

  localparam logic [DATA_W-1:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Register state
  logic                  en_q, en_d;
  logic                  autoreload_q, autoreload_d;
  logic                  irqen_q, irqen_d;
  logic [DATA_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]     compare_q, compare_d;
  logic                  match_q, match_d;
  logic                  ovf_q, ovf_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  irq_q, irq_d;

  // Decode
  logic [OFF_W-1:0] offset;
  logic             wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
  logic             tick;
  logic             match_set, ovf_set;
  logic [DATA_W-1:0] rdata;

  // Byte lanes are not decoded; every access is a full word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^DataAdr[1:0];

  // Window decode and per-register write enables
  always_comb begin
    hit         = (DataAdr[31:5] == BASE[31:5]);
    offset      = DataAdr[4:2];
    wr_ctrl     = MemWrite && hit && (offset == OFF_CTRL);
    wr_count    = MemWrite && hit && (offset == OFF_COUNT);
    wr_compare  = MemWrite && hit && (offset == OFF_COMPARE);
    wr_status   = MemWrite && hit && (offset == OFF_STATUS);
    wr_prescale = MemWrite && hit && (offset == OFF_PRESCALE);
  end

  // Prescaler: tick on the cycle pcnt reaches PRESCALE, then restart from 0
  always_comb begin
    tick   = en_q && (pcnt_q == prescale_q);
    pcnt_d = pcnt_q;
    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
    // A new prescale value restarts the period from zero.
    if (wr_prescale) begin
      pcnt_d = '0;
    end
  end

  // Counter, compare and flags. Hardware events are computed from the pre-edge
  // values; bus writes then override COUNT and EN, while flag sets beat W1C.
  always_comb begin
    count_d      = count_q;
    compare_d    = compare_q;
    en_d         = en_q;
    autoreload_d = autoreload_q;
    irqen_d      = irqen_q;
    prescale_d   = prescale_q;
    match_set    = 1'b0;
    ovf_set      = 1'b0;

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        if (autoreload_q) begin
          count_d = '0;
        end else begin
          en_d = 1'b0;
        end
      end else if (count_q == COUNT_MAX) begin
        count_d = '0;
        ovf_set = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl) begin
      en_d         = WriteData[0];
      autoreload_d = WriteData[1];
      irqen_d      = WriteData[2];
    end
    if (wr_count) begin
      count_d = WriteData;
    end
    if (wr_compare) begin
      compare_d = WriteData;
    end
    if (wr_prescale) begin
      prescale_d = WriteData[PRESCALE_W-1:0];
    end

    match_d = (match_q && !(wr_status && WriteData[0])) || match_set;
    ovf_d   = (ovf_q   && !(wr_status && WriteData[1])) || ovf_set;

    // irq tracks the post-edge flag so it rises together with MATCH.
    irq_d = match_d && irqen_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irqen_q      <= 1'b0;
      count_q      <= '0;
      compare_q    <= '0;
      match_q      <= 1'b0;
      ovf_q        <= 1'b0;
      prescale_q   <= '0;
      pcnt_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      irqen_q      <= irqen_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      match_q      <= match_d;
      ovf_q        <= ovf_d;
      prescale_q   <= prescale_d;
      pcnt_q       <= pcnt_d;
      irq_q        <= irq_d;
    end
  end

  // Read mux; reads have no side effects
  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_CTRL:     rdata = {29'd0, irqen_q, autoreload_q, en_q};
      OFF_COUNT:    rdata = count_q;
      OFF_COMPARE:  rdata = compare_q;
      OFF_STATUS:   rdata = {30'd0, ovf_q, match_q};
      OFF_PRESCALE: rdata = DATA_W'(prescale_q);
      default:      rdata = '0;
    endcase
    ReadData = hit ? rdata : '0;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios followed by randomized
// bus traffic, checked against an event-ordered behavioural model.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_CNT  = BASE + 32'h04;
  localparam logic [31:0] A_CMP  = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_PRE  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mmio_timer #(.BASE(BASE), .PRESCALE_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_count, m_cmp;
  logic [15:0] m_pre, m_pcnt;
  logic        m_en, m_ar, m_ie, m_match, m_ovf, m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[4:2])
      3'd0:    return {29'd0, m_ie, m_ar, m_en};
      3'd1:    return m_count;
      3'd2:    return m_cmp;
      3'd3:    return {30'd0, m_ovf, m_match};
      3'd4:    return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_count = 0; m_cmp = 0; m_pre = 0; m_pcnt = 0;
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_ovf = 0; m_irq = 0;
  endtask

  // One clock edge: the timer reacts first, then the bus write is applied on top,
  // and finally hardware flag sets are re-asserted so they beat a same-cycle clear.
  task automatic m_edge(input logic rst_n, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic tick, set_match, set_ovf;
    if (!rst_n) begin
      m_reset();
      return;
    end
    tick = m_en && (m_pcnt == m_pre);
    set_match = 0;
    set_ovf = 0;
    if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    if (tick) begin
      if (m_count == m_cmp) begin
        set_match = 1;
        if (m_ar) m_count = 0;
        else      m_en = 0;
      end else if (m_count == 32'hFFFF_FFFF) begin
        m_count = 0;
        set_ovf = 1;
      end else begin
        m_count = m_count + 1;
      end
    end
    if (we && m_hit(a)) begin
      case (a[4:2])
        3'd0: begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
        3'd1: m_count = d;
        3'd2: m_cmp = d;
        3'd3: begin if (d[0]) m_match = 0; if (d[1]) m_ovf = 0; end
        3'd4: begin m_pre = d[15:0]; m_pcnt = 0; end
        default: ;
      endcase
    end
    if (set_match) m_match = 1;
    if (set_ovf)   m_ovf = 1;
    m_irq = m_match && m_ie;
  endtask

  // One bus cycle: check the combinational read, cross one edge, check irq.
  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rv);
    MemWrite = we; DataAdr = a; WriteData = d;
    #1;
    check("hit", 32'(hit), 32'(m_hit(a)));
    check("rdata", ReadData, m_read(a));
    rv = ReadData;
    @(posedge clk);
    m_edge(reset, we, a, d);
    #1;
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rv;
    bus(1'b1, a, d, rv);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] rv);
    bus(1'b0, a, 32'd0, rv);
  endtask

  task automatic idle(input int n);
    logic [31:0] rv;
    for (int i = 0; i < n; i++) bus(1'b0, A_CNT, 32'd0, rv);
  endtask

  task automatic do_reset();
    reset = 1'b0; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] a, d;
    logic        we;
    int          r;
    logic [31:0] ar_seq [6];
    ar_seq[0] = 0; ar_seq[1] = 1; ar_seq[2] = 2; ar_seq[3] = 0; ar_seq[4] = 1; ar_seq[5] = 2;

    // Reset state and decode
    do_reset();
    check("irq_after_reset", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(4 * i), rv);
      check("reset_reg", rv, 32'd0);
    end
    rd(32'h0000_0FFC, rv);
    check("miss_hit", 32'(hit), 32'd0);
    check("miss_rdata", rv, 32'd0);

    // Prescaled count, then EN stall/resume
    wr(A_PRE, 32'd3);
    wr(A_CMP, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'd1);
    idle(20);
    rd(A_CNT, rv);
    check("prescaled_count", rv, 32'd5);
    idle(1);
    wr(A_CTRL, 32'd0);
    idle(5);
    wr(A_CTRL, 32'd1);
    idle(1);
    rd(A_CNT, rv);
    check("resume_count", rv, 32'd6);

    // One-shot match
    do_reset();
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd4);
    wr(A_CTRL, 32'd5);
    idle(5);
    check("oneshot_irq", 32'(irq), 32'd1);
    rd(A_STAT, rv); check("oneshot_match", rv, 32'd1);
    rd(A_CNT, rv);  check("oneshot_hold", rv, 32'd4);
    rd(A_CTRL, rv); check("oneshot_ctrl", rv, 32'd4);
    wr(A_STAT, 32'd1);
    check("w1c_irq", 32'(irq), 32'd0);
    rd(A_STAT, rv); check("w1c_match", rv, 32'd0);

    // Auto-reload sequence
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'd3);
    for (int i = 0; i < 6; i++) begin
      rd(A_CNT, rv);
      check("autoreload_seq", rv, ar_seq[i]);
    end
    rd(A_STAT, rv); check("autoreload_match", rv, 32'd1);

    // Overflow
    do_reset();
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'h10);
    wr(A_CTRL, 32'd1);
    idle(2);
    rd(A_CNT, rv);  check("ovf_count", rv, 32'd0);
    rd(A_STAT, rv); check("ovf_status", rv, 32'd2);

    // COUNT write in a tick cycle wins
    wr(A_CNT, 32'h100);
    rd(A_CNT, rv); check("count_write_wins", rv, 32'h100);

    // W1C in the cycle a match sets MATCH keeps it set
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'd3);
    idle(2);
    wr(A_STAT, 32'd1);
    rd(A_STAT, rv); check("w1c_collision", rv & 32'd1, 32'd1);

    // Reset mid-count discards everything
    wr(A_PRE, 32'd2);
    idle(3);
    reset = 1'b0;
    rd(A_CNT, rv);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 32'(4 * i), rv);
      check("midcount_reset", rv, 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 199);
      a  = {BASE[31:5], 3'($urandom_range(0, 7)), 2'($urandom)};
      if (r < 4) a = $urandom;
      we = (r < 70);
      case (a[4:2])
        3'd0: begin d = $urandom; if ($urandom_range(0, 3) != 0) d[0] = 1'b1; end
        3'd1: d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4))
                                               : 32'($urandom_range(0, 30));
        3'd2: d = 32'($urandom_range(0, 30));
        3'd4: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      if (r == 199) reset = 1'b0;
      bus(we, a, d, rv);
      reset = 1'b1;
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/counter peripheral that acts as a responder on the ARMSC data bus (MemWrite, DataAdr, WriteData, ReadData).
- Sits beside dmem. The top-level mux selects this block's ReadData when its hit output is high.
- Provides a prescaled 32-bit up-counter, a compare match with optional auto-reload, an overflow flag and a level interrupt.
- Firmware uses it for timed loops and for delays that can be checked in simulation.

Parameters:
- BASE, 32'h0000_1000, byte base address of the 32-byte register window; must be 32-byte aligned.
- PRESCALE_W, 16, width of the prescaler register and the prescaler counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- MemWrite  in  1  write strobe from the processor; a write commits at the clk edge.
- DataAdr  in  32  byte address from the processor.
- WriteData  in  32  write data.
- ReadData  out  32  read data; combinational, valid in the same cycle as DataAdr.
- hit  out  1  combinational; high when DataAdr[31:5] == BASE[31:5].
- irq  out  1  registered interrupt; high when STATUS.MATCH=1 and CTRL.IRQEN=1.

Behaviour:
- Decode: offset = DataAdr[4:2]; DataAdr[1:0] are ignored. A write takes effect only when MemWrite=1 and hit=1.
- Offset 0, CTRL (R/W): bit0 EN, bit1 AUTORELOAD, bit2 IRQEN. Other bits read 0.
- Offset 1, COUNT (R/W): 32-bit counter value.
- Offset 2, COMPARE (R/W): 32-bit compare value.
- Offset 3, STATUS (R/W1C): bit0 MATCH, bit1 OVF. Writing 1 to a bit clears it; writing 0 has no effect.
- Offset 4, PRESCALE (R/W): low PRESCALE_W bits; upper bits read 0.
- Offsets 5-7: read 0, writes ignored.
- ReadData is 0 whenever hit=0.
- Reset (reset=0 at an edge): all registers go to 0, including the prescaler counter pcnt. irq=0. Reset overrides any bus write in the same cycle; a reset mid-count discards all progress.
- Prescaler:
  - pcnt advances only while EN=1.
  - tick=1 in a cycle where EN=1 and pcnt==PRESCALE; pcnt then goes to 0. Otherwise pcnt increments.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - Clearing EN freezes pcnt. Any write to PRESCALE clears pcnt.
- Counter update on a tick:
  - If COUNT==COMPARE: set MATCH. If AUTORELOAD=1, COUNT goes to 0. If AUTORELOAD=0, COUNT holds and EN clears (one-shot).
  - Else if COUNT==32'hFFFF_FFFF: COUNT wraps to 0 and OVF is set.
  - Else: COUNT increments by 1.
  - Counter latency: COUNT changes at the clk edge that ends the tick cycle.
- Simultaneous events:
  - A bus write to COUNT in a tick cycle wins; the tick's effect on COUNT is dropped.
  - A bus write to CTRL in a one-shot match cycle: the written EN value wins.
  - A STATUS W1C in the same cycle as a hardware set of that bit: the set wins, and the bit stays 1.
  - A compare evaluates the pre-edge COUNT and COMPARE values. A same-cycle write to COMPARE affects the next tick only.
- irq is registered: irq(next) = MATCH(next) & IRQEN(next). It therefore rises one edge after the setting tick, in the same cycle MATCH reads 1.
- Reads have no side effects.

Test Plan:
- Reset and decode: hold reset=0 for 2 cycles, then read BASE+0..0x1C → all reads 0, irq=0. Read DataAdr=0x0000_0FFC → hit=0, ReadData=0.
- Prescaled count: PRESCALE=3, COMPARE=0xFFFF_FFFF, CTRL=1. Wait 20 cycles after the CTRL write → COUNT=5. pcnt stalls when EN is cleared and resumes from the same value when EN is set again.
- One-shot match: PRESCALE=0, COMPARE=4, CTRL=0x5. After 5 ticks → MATCH=1, COUNT holds at 4, CTRL reads 0x4, irq=1 one edge later. Write STATUS=1 → MATCH=0 and irq=0 on the following cycle.
- Auto-reload: PRESCALE=0, COMPARE=2, CTRL=0x3 → COUNT sequence 0,1,2,0,1,2; MATCH set at the first 2 and stays set.
- Overflow: COUNT=0xFFFF_FFFE, COMPARE=0x10, CTRL=1 → after 2 ticks COUNT=0 and OVF=1, MATCH=0.
- Collisions: write COUNT=0x100 in a tick cycle → reads 0x100, not 0x101. W1C of MATCH in the cycle a match sets it → MATCH=1. Assert reset mid-count → all registers 0 on the next cycle.
